key_converter: RTL and testbench
================================

Name: key_converter

Overview:
- Translates the raw 8-bit ASCII keyboard byte into the 4-bit key enumeration consumed by the game state machine.
- Codes: W, A, S, D = movement; J, K, L = action; SPACE = start.
- Sits between the keyboard/UART receive register and the game controller.
- Output is registered, with an optional stability (debounce) filter so a transient byte cannot produce a key event.

Parameters:
- STABLE_CYCLES, 1, consecutive clock edges the keyboard byte must be sampled unchanged before key updates. Legal range 1..255. With 1, the block is a plain one-cycle registered decode.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous and active-low. One clock; reset is asynchronous and active-low.
- key  output  4  decoded key enum (registered).
- keyboard  input  8  ASCII code of the currently pressed key; 0x00 = no key.

Behaviour:
- Decode table (both upper- and lower-case accepted):
  - 0x57/0x77 'W' -> 4'd1
  - 0x41/0x61 'A' -> 4'd2
  - 0x53/0x73 'S' -> 4'd3
  - 0x44/0x64 'D' -> 4'd4
  - 0x4A/0x6A 'J' -> 4'd5
  - 0x4B/0x6B 'K' -> 4'd6
  - 0x4C/0x6C 'L' -> 4'd7
  - 0x20 space -> 4'd8
  - every other value, including 0x00, -> 4'd0 (ZERO/idle)
  - codes 9..15 are never produced.
- Internal state:
  - last_code[7:0]: last sampled byte.
  - cnt[7:0]: consecutive equal samples, saturating at STABLE_CYCLES.
- Reset (rst_n low, asynchronous):
  - key = 0, last_code = 0x00, cnt = STABLE_CYCLES.
  - key stays 0 while rst_n is low, regardless of clk.
  - Reset asserted mid-filter discards the pending byte.
- Each rising clk edge, when not in reset:
  - If keyboard != last_code: last_code <= keyboard, cnt <= 1. If STABLE_CYCLES == 1, key <= decode(keyboard) on this same edge.
  - Else if cnt < STABLE_CYCLES: cnt <= cnt + 1. If cnt + 1 == STABLE_CYCLES, key <= decode(keyboard).
  - Else: hold; key is unchanged.
- Latency: key reflects a new stable byte exactly STABLE_CYCLES rising edges after the byte first appears at a sampling edge. For the default, this is 1 edge.
- A byte that changes before STABLE_CYCLES samples never reaches key. key holds its previous value and filtering restarts with the new byte.
- Changing from one valid key to another follows the same rule. There is no forced pass through 0.
- key is level, not pulse: it stays at the decoded value as long as keyboard holds the byte.
- Releasing a key (byte -> 0x00) returns key to 0 after the same latency.
- The output must never be X or Z after reset, including for an X-free but unmapped input.

Test Plan:
- Reset: rst_n = 0 with keyboard = 0x57 -> key = 0 throughout. Release reset with default params -> key = 1 one edge later.
- Full decode sweep, STABLE_CYCLES = 1: apply every value 0x00..0xFF for 2 cycles each.
  - key = 1..8 exactly for the 15 listed codes (e.g. 0x61 -> 2, 0x20 -> 8, 0x6C -> 7).
  - key = 0 for the other 241 values.
- Latency/level: keyboard 0x00 -> 0x73 at an edge -> key = 3 on the next edge and held 10 cycles. Then 0x00 -> key = 0 one edge later.
- Filter, STABLE_CYCLES = 4:
  - 0x44 held for 3 edges, then 0x00 -> key never leaves 0.
  - 0x44 held for 4 edges -> key = 4 on the 4th edge.
- Direct key change: 0x57 stable (key = 1), then 0x53 -> key goes straight to 3 with no intermediate 0.
- Async reset mid-operation: key = 8 (space held); assert rst_n between edges -> key = 0 immediately. Deassert with space still held -> key = 8 after STABLE_CYCLES edges.

Source files
------------

// File: rtl/key_converter.sv
// key_converter
//   Translates the raw ASCII keyboard byte into the 4-bit key enumeration used
//   by the game controller. An optional stability filter requires the byte to
//   be sampled unchanged for STABLE_CYCLES edges before key follows it.
//
// Ports
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   keyboard  ASCII code of the pressed key, 0x00 = no key
//   key       decoded key enum (registered): 1..4 WASD, 5..7 JKL, 8 space, 0 idle
module key_converter #(
  parameter int unsigned STABLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] keyboard,
  output logic [3:0] key
);

  localparam int unsigned CODE_W = 8;
  localparam int unsigned KEY_W  = 4;
  localparam int unsigned CNT_W  = 8;

  localparam logic [CNT_W-1:0] STABLE_CNT = CNT_W'(STABLE_CYCLES);
  localparam bit               FAST       = (STABLE_CYCLES == 1);

  localparam logic [KEY_W-1:0] KEY_IDLE  = 4'd0;
  localparam logic [KEY_W-1:0] KEY_UP    = 4'd1;
  localparam logic [KEY_W-1:0] KEY_LEFT  = 4'd2;
  localparam logic [KEY_W-1:0] KEY_DOWN  = 4'd3;
  localparam logic [KEY_W-1:0] KEY_RIGHT = 4'd4;
  localparam logic [KEY_W-1:0] KEY_J     = 4'd5;
  localparam logic [KEY_W-1:0] KEY_K     = 4'd6;
  localparam logic [KEY_W-1:0] KEY_L     = 4'd7;
  localparam logic [KEY_W-1:0] KEY_START = 4'd8;

  logic [CODE_W-1:0] last_code;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_inc_c;
  logic [KEY_W-1:0]  decoded_c;

  // ASCII to key enum; both letter cases map to the same key, anything else idles
  always_comb begin
    decoded_c = KEY_IDLE;
    unique case (keyboard)
      8'h57, 8'h77: decoded_c = KEY_UP;
      8'h41, 8'h61: decoded_c = KEY_LEFT;
      8'h53, 8'h73: decoded_c = KEY_DOWN;
      8'h44, 8'h64: decoded_c = KEY_RIGHT;
      8'h4A, 8'h6A: decoded_c = KEY_J;
      8'h4B, 8'h6B: decoded_c = KEY_K;
      8'h4C, 8'h6C: decoded_c = KEY_L;
      8'h20:        decoded_c = KEY_START;
      default:      decoded_c = KEY_IDLE;
    endcase
  end

  // cnt stays below STABLE_CNT (<= 255) whenever this is used, so no wrap
  assign cnt_inc_c = cnt + CNT_W'(1);

  // Stability filter: a new byte restarts the count; key loads when the count
  // reaches STABLE_CNT and then holds until the byte changes again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key       <= KEY_IDLE;
      last_code <= '0;
      cnt       <= STABLE_CNT;
    end else if (keyboard != last_code) begin
      last_code <= keyboard;
      cnt       <= CNT_W'(1);
      if (FAST) key <= decoded_c;
    end else if (cnt < STABLE_CNT) begin
      cnt <= cnt_inc_c;
      if (cnt_inc_c == STABLE_CNT) key <= decoded_c;
    end
  end

endmodule

// File: tb/tb_key_converter.sv
// Directed bench for key_converter: one instance with the default plain decode
// and one with a 4-sample stability filter, both fed the same keyboard byte.
module tb_key_converter;

  logic       clk;
  logic       rst_n;
  logic [7:0] keyboard;
  logic [3:0] key1;
  logic [3:0] key4;

  int checks;
  int errors;

  key_converter #(.STABLE_CYCLES(1)) dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .keyboard (keyboard),
    .key      (key1)
  );

  key_converter #(.STABLE_CYCLES(4)) dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .keyboard (keyboard),
    .key      (key4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode table, written out as code/value pairs
  logic [7:0] ref_codes [15];
  logic [3:0] ref_vals  [15];

  function automatic logic [3:0] ref_decode(input logic [7:0] b);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < 15; i++)
      if (ref_codes[i] == b) r = ref_vals[i];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int hits;
    checks = 0;
    errors = 0;
    hits   = 0;
    ref_codes = '{8'h57, 8'h77, 8'h41, 8'h61, 8'h53, 8'h73, 8'h44, 8'h64,
                  8'h4A, 8'h6A, 8'h4B, 8'h6B, 8'h4C, 8'h6C, 8'h20};
    ref_vals  = '{4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3, 4'd4, 4'd4,
                  4'd5, 4'd5, 4'd6, 4'd6, 4'd7, 4'd7, 4'd8};

    // Reset held with 'W' present: key must stay idle across edges
    rst_n    = 1'b0;
    keyboard = 8'h57;
    #1;
    check("reset_async_k1", key1, 4'd0);
    check("reset_async_k4", key4, 4'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_hold_k1", key1, 4'd0);
      check("reset_hold_k4", key4, 4'd0);
    end
    rst_n = 1'b1;

    // After release: default instance one edge, filtered instance four edges
    tick();
    check("rel_k1_edge1", key1, 4'd1);
    check("rel_k4_edge1", key4, 4'd0);
    tick();
    check("rel_k4_edge2", key4, 4'd0);
    tick();
    check("rel_k4_edge3", key4, 4'd0);
    tick();
    check("rel_k4_edge4", key4, 4'd1);

    // Full decode sweep on the plain instance
    for (int v = 0; v < 256; v++) begin
      keyboard = 8'(v);
      tick();
      check("sweep_e1", key1, ref_decode(8'(v)));
      tick();
      check("sweep_e2", key1, ref_decode(8'(v)));
      if (key1 != 4'd0) hits++;
    end
    checks++;
    assert (hits == 15)
    else begin
      errors++;
      $error("FAIL sweep_nonzero_count observed=%0d expected=15", hits);
    end

    // Spot checks of specific codes
    keyboard = 8'h61; tick(); check("spot_a_lower", key1, 4'd2);
    keyboard = 8'h20; tick(); check("spot_space", key1, 4'd8);
    keyboard = 8'h6C; tick(); check("spot_l_lower", key1, 4'd7);

    // Latency and level behaviour
    keyboard = 8'h00;
    tick();
    check("lvl_idle", key1, 4'd0);
    keyboard = 8'h73;
    tick();
    check("lvl_first", key1, 4'd3);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("lvl_hold", key1, 4'd3);
    end
    keyboard = 8'h00;
    tick();
    check("lvl_release", key1, 4'd0);

    // Filtered instance: let it settle idle
    for (int i = 0; i < 5; i++) tick();
    check("flt_idle", key4, 4'd0);

    // 'D' for only 3 edges must never reach key
    keyboard = 8'h44;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("flt_short_d", key4, 4'd0);
    end
    keyboard = 8'h00;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("flt_short_after", key4, 4'd0);
    end

    // 'D' for 4 edges appears on the 4th
    keyboard = 8'h44;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("flt_full_wait", key4, 4'd0);
    end
    tick();
    check("flt_full_edge4", key4, 4'd4);

    // Direct change W -> S without passing through idle
    keyboard = 8'h57;
    for (int i = 0; i < 4; i++) tick();
    check("chg_w_k1", key1, 4'd1);
    check("chg_w_k4", key4, 4'd1);
    keyboard = 8'h53;
    tick();
    check("chg_s_k1", key1, 4'd3);
    check("chg_s_k4_e1", key4, 4'd1);
    tick();
    check("chg_s_k4_e2", key4, 4'd1);
    tick();
    check("chg_s_k4_e3", key4, 4'd1);
    tick();
    check("chg_s_k4_e4", key4, 4'd3);

    // Async reset mid-operation with space held
    keyboard = 8'h20;
    for (int i = 0; i < 4; i++) tick();
    check("ar_pre_k1", key1, 4'd8);
    check("ar_pre_k4", key4, 4'd8);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_now_k1", key1, 4'd0);
    check("ar_now_k4", key4, 4'd0);
    tick();
    check("ar_edge_k1", key1, 4'd0);
    check("ar_edge_k4", key4, 4'd0);
    rst_n = 1'b1;
    tick();
    check("ar_rel_k1", key1, 4'd8);
    check("ar_rel_k4_e1", key4, 4'd0);
    tick();
    check("ar_rel_k4_e2", key4, 4'd0);
    tick();
    check("ar_rel_k4_e3", key4, 4'd0);
    tick();
    check("ar_rel_k4_e4", key4, 4'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
